dkong3_vram_arb: RTL
====================

# dkong3_vram_arb

Time-slot arbiter sharing the single-port tile VRAM between the CPU and the video tile fetch. Slots are derived from the horizontal counter and composite blank produced by the H/V counter. Video fetch owns fixed slots in every 8-pixel group during active display. The CPU gets every other slot, and is stalled through a Z80-style WAIT_n until its access completes.

## Interface
- AW, 10, VRAM address width
- DW, 8, VRAM data width
- VID_PHASE, 0, H_CNT[2:0] value at which the video slot starts
- VID_LEN, 2, video slots per 8-pixel group (1..7)

Ports:
- I_CLK  in  1  system clock, 24.576 MHz
- I_RST_n  in  1  reset, asynchronous, active-low
- I_PIX_CE  in  1  one-I_CLK strobe per H_CNT increment (slot boundary)
- I_H_CNT  in  10  horizontal count from the H/V counter
- I_C_BLANKn  in  1  composite blank, low = blanking
- I_VID_ADDR  in  AW  tile fetch address
- O_VID_DATA  out  DW  last video read data
- O_VID_VALID  out  1  one-cycle pulse when O_VID_DATA updates
- I_CPU_CS  in  1  CPU VRAM select, level
- I_CPU_WR  in  1  1 = write
- I_CPU_ADDR  in  AW  CPU address
- I_CPU_DO  in  DW  CPU write data
- O_CPU_DI  out  DW  CPU read data, held until the next CPU read completes
- O_CPU_WAITn  out  1  low = stall CPU
- O_RAM_A  out  AW  VRAM address
- O_RAM_DI  out  DW  VRAM write data
- O_RAM_WE  out  1  VRAM write enable
- I_RAM_DO  in  DW  VRAM read data, valid one slot after the address is applied

## Operation
- Slot classification is evaluated in the cycle I_PIX_CE is high, using the current I_H_CNT:
  - The slot is a video slot (VSLOT) when I_C_BLANKn = 1 and ((I_H_CNT[2:0] − VID_PHASE) mod 8) < VID_LEN, using 3-bit wrap arithmetic.
  - Every other slot is free.
- Owner register takes one of three values: NONE, VID, CPU. The owner is set at each strobe and drives O_RAM_* for the whole slot.
- Video has absolute priority. In a VSLOT, owner = VID, O_RAM_A = I_VID_ADDR sampled at the strobe, and O_RAM_WE = 0.
- CPU FSM states: IDLE, ACC, DONE.
  - IDLE → ACC at a strobe where I_CPU_CS = 1 and the slot is free. On entry:
    - O_RAM_A = I_CPU_ADDR
    - O_RAM_DI = I_CPU_DO
    - O_RAM_WE = I_CPU_WR
    - owner = CPU
  - ACC → DONE at the next strobe. On a read, I_RAM_DO is captured into O_CPU_DI. O_RAM_WE drops at this strobe, so a write lasts exactly one slot.
  - ACC → IDLE instead of DONE if I_CPU_CS = 0 at that strobe. The access is still completed: a write is committed and read data is captured.
  - DONE → IDLE in the first I_CLK cycle in which I_CPU_CS = 0. No strobe is required.
- O_CPU_WAITn = ~(I_CPU_CS & state ≠ DONE). This output is combinational, so the CPU sees a stall in the same cycle it asserts CS.
- Video read completion: at the strobe ending a VID slot, I_RAM_DO is captured into O_VID_DATA and O_VID_VALID pulses for one cycle. Back-to-back VSLOTs produce back-to-back captures.
- Simultaneous events:
  - CPU pending when a VSLOT starts: the CPU stays in IDLE and waits.
  - Strobe that ends ACC and starts a VSLOT: both transitions occur in the same cycle.
  - I_C_BLANKn falling mid-group: the very next strobe is free.
- Reset mid-operation:
  - The FSM returns to IDLE and owner to NONE.
  - O_RAM_WE = 0 immediately.
  - A write in flight is abandoned.
- Reset values: O_VID_DATA = 0, O_VID_VALID = 0, O_CPU_DI = 0, O_RAM_A = 0, O_RAM_DI = 0, O_RAM_WE = 0. O_CPU_WAITn = ~I_CPU_CS.

## Timing
- All registers update on the posedge of I_CLK and change only in I_PIX_CE cycles. The exception is the DONE → IDLE transition, which may happen in any cycle.
- Video latency: address at strobe n, data and VALID at strobe n+1.
- CPU best-case latency: CS asserted before strobe n in a free slot → WAITn high one I_CLK after strobe n+1.
- CPU worst-case stall during active display: VID_LEN + 1 slots after the first strobe seen with CS asserted.
- During blanking there are no VSLOTs, so the CPU always completes in 1 slot after its first strobe.

## Configuration
- DKONG3_VRAM_ARB_STATS_EN defined: adds output O_WAIT_MAX[7:0].
  - A per-request counter counts strobes during which CS = 1 in IDLE.
  - O_WAIT_MAX holds the maximum count since reset, saturating at 255.
  - It is cleared by reset only.
- Undefined: the port and counters are absent; arbitration is unchanged.

## Test plan
- Video only, VID_PHASE = 0, VID_LEN = 2, active line, I_VID_ADDR = 0x123, RAM returns 0x5A: O_RAM_A = 0x123 during H_CNT[2:0] = 0,1; O_VID_DATA = 0x5A; VALID pulses at the strobes for H_CNT[2:0] = 1 and 2.
- CPU write 0xA5 to 0x040 arriving at H_CNT[2:0] = 7 during active display: granted at the strobe for H_CNT[2:0] = 2; O_RAM_WE high for exactly one slot; WAITn low for 3 slots.
- CPU read 0x3FF during blank, RAM returns 0x77: O_CPU_DI = 0x77 one slot after grant; WAITn stays high until CS is released, then the FSM returns to IDLE.
- CS deasserted during ACC: the write still lands; the FSM goes to IDLE with no DONE state; the next CS is stalled normally.
- Reset asserted during ACC write: O_RAM_WE = 0 immediately, all outputs at reset values; normal operation resumes after release.
- With DKONG3_VRAM_ARB_STATS_EN: the worst-case request above → O_WAIT_MAX = 3; a 300-strobe forced stall saturates O_WAIT_MAX at 255.

Source files
------------

// File: rtl/dkong3_vram_arb.sv
// dkong3_vram_arb: time-slot arbiter for the single-port tile VRAM.
// Video tile fetch owns VID_LEN slots per 8-pixel group during active
// display; the CPU is granted free slots and held off through O_CPU_WAITn.
// Optional build macro DKONG3_VRAM_ARB_STATS_EN adds O_WAIT_MAX, the worst
// CPU wait (in strobes) seen since reset, saturating at 255.
module dkong3_vram_arb #(
   parameter int AW        = 10,
   parameter int DW        = 8,
   parameter int VID_PHASE = 0,
   parameter int VID_LEN   = 2
) (
   input  logic          I_CLK,
   input  logic          I_RST_n,
   input  logic          I_PIX_CE,
   input  logic [9:0]    I_H_CNT,
   input  logic          I_C_BLANKn,
   input  logic [AW-1:0] I_VID_ADDR,
   output logic [DW-1:0] O_VID_DATA,
   output logic          O_VID_VALID,
   input  logic          I_CPU_CS,
   input  logic          I_CPU_WR,
   input  logic [AW-1:0] I_CPU_ADDR,
   input  logic [DW-1:0] I_CPU_DO,
   output logic [DW-1:0] O_CPU_DI,
   output logic          O_CPU_WAITn,
   output logic [AW-1:0] O_RAM_A,
   output logic [DW-1:0] O_RAM_DI,
   output logic          O_RAM_WE,
   input  logic [DW-1:0] I_RAM_DO
`ifdef DKONG3_VRAM_ARB_STATS_EN
   ,
   output logic [7:0]    O_WAIT_MAX
`endif
);

   localparam logic [2:0] PHASE = 3'(VID_PHASE);
   localparam logic [2:0] LEN   = 3'(VID_LEN);

   typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
   typedef enum logic [1:0] {CPU_IDLE, CPU_ACC, CPU_DONE} cpu_state_t;

   owner_t     owner;
   cpu_state_t cpu_state;

   logic [2:0] slot_ofs;
   logic       vslot;
   logic       grant;

   // Only the low three bits of the horizontal count select the slot.
   logic       unused_hcnt;
   assign unused_hcnt = ^I_H_CNT[9:3];

   // Slot classification and CPU grant for the slot starting at this strobe.
   always_comb begin
      slot_ofs = I_H_CNT[2:0] - PHASE;
      vslot    = I_C_BLANKn & (slot_ofs < LEN);
      grant    = I_PIX_CE & I_CPU_CS & (cpu_state == CPU_IDLE) & ~vslot;
   end

   // Stall whenever the CPU selects VRAM and its access has not finished.
   assign O_CPU_WAITn = ~(I_CPU_CS & (cpu_state != CPU_DONE));

   // Slot owner and VRAM port drive; video capture at the end of a video slot.
   always_ff @(posedge I_CLK or negedge I_RST_n) begin
      if (!I_RST_n) begin
         owner       <= OWN_NONE;
         O_RAM_A     <= '0;
         O_RAM_DI    <= '0;
         O_RAM_WE    <= 1'b0;
         O_VID_DATA  <= '0;
         O_VID_VALID <= 1'b0;
      end else begin
         O_VID_VALID <= 1'b0;
         if (I_PIX_CE) begin
            if (owner == OWN_VID) begin
               O_VID_DATA  <= I_RAM_DO;
               O_VID_VALID <= 1'b1;
            end
            O_RAM_WE <= 1'b0;
            if (vslot) begin
               owner   <= OWN_VID;
               O_RAM_A <= I_VID_ADDR;
            end else if (grant) begin
               owner    <= OWN_CPU;
               O_RAM_A  <= I_CPU_ADDR;
               O_RAM_DI <= I_CPU_DO;
               O_RAM_WE <= I_CPU_WR;
            end else begin
               owner <= OWN_NONE;
            end
         end
      end
   end

   // CPU access sequencer; read data is captured when the access slot ends.
   // O_RAM_WE still holds the access direction during ACC, so it doubles as
   // the read/write flag at the closing strobe.
   always_ff @(posedge I_CLK or negedge I_RST_n) begin
      if (!I_RST_n) begin
         cpu_state <= CPU_IDLE;
         O_CPU_DI  <= '0;
      end else begin
         case (cpu_state)
            CPU_IDLE: begin
               if (grant)
                  cpu_state <= CPU_ACC;
            end
            CPU_ACC: begin
               if (I_PIX_CE) begin
                  if (!O_RAM_WE)
                     O_CPU_DI <= I_RAM_DO;
                  cpu_state <= I_CPU_CS ? CPU_DONE : CPU_IDLE;
               end
            end
            CPU_DONE: begin
               if (!I_CPU_CS)
                  cpu_state <= CPU_IDLE;
            end
            default: cpu_state <= CPU_IDLE;
         endcase
      end
   end

`ifdef DKONG3_VRAM_ARB_STATS_EN
   logic [7:0] wait_cnt;
   logic [7:0] wait_inc;

   // Saturating increment of the current request's wait count.
   always_comb begin
      wait_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
   end

   // Count strobes a request spends in IDLE and track the worst case.
   always_ff @(posedge I_CLK or negedge I_RST_n) begin
      if (!I_RST_n) begin
         wait_cnt   <= '0;
         O_WAIT_MAX <= '0;
      end else if (I_PIX_CE) begin
         if (cpu_state == CPU_IDLE && I_CPU_CS) begin
            wait_cnt <= grant ? 8'h00 : wait_inc;
            if (wait_inc > O_WAIT_MAX)
               O_WAIT_MAX <= wait_inc;
         end else begin
            wait_cnt <= '0;
         end
      end
   end
`endif

endmodule
